// File: rtl/eda_region_pkg.sv
// Shared types for the regional-maximum flood-fill sequencer: FSM state
// encoding, address/size width derivations and the read-latency bound.
package eda_region_pkg;

  localparam int RD_LATENCY_MAX = 7;
  localparam int WAIT_CNT_W     = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEED   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_EVAL   = 3'd3,
    ST_EXTEND = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  function automatic int addr_width(input int i_w, input int j_w);
    return i_w + j_w;
  endfunction

  function automatic int size_width(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/eda_region_ctrl_if.sv
// Bundle between the flood-fill sequencer (master) and the evaluator,
// neighbour FIFOs and pixel/label RAMs (slave).
interface eda_region_ctrl_if
  import eda_region_pkg::*;
#(
  parameter int I_WIDTH    = 8,
  parameter int J_WIDTH    = 8,
  parameter int NUM_FIFO   = 8,
  parameter int ADDR_WIDTH = addr_width(I_WIDTH, J_WIDTH),
  parameter int SIZE_WIDTH = size_width(ADDR_WIDTH)
);
  logic                  start;
  logic                  abort;
  logic                  stall;
  logic                  iterated_all;
  logic [NUM_FIFO-1:0]   fifo_empty;
  logic [NUM_FIFO-1:0]   push_positions;
  logic [ADDR_WIDTH-1:0] data_out;
  logic [I_WIDTH-1:0]    next_row;
  logic [J_WIDTH-1:0]    next_col;

  logic                  new_pixel;
  logic [ADDR_WIDTH-1:0] center_addr;
  logic [NUM_FIFO-1:0]   read_en;
  logic                  clear;
  logic                  update_strb;
  logic                  region_end;
  logic [SIZE_WIDTH-1:0] region_size;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, abort, stall, iterated_all, fifo_empty, push_positions,
           data_out, next_row, next_col,
    output new_pixel, center_addr, read_en, clear, update_strb, region_end,
           region_size, busy, done
  );

  modport slave (
    output start, abort, stall, iterated_all, fifo_empty, push_positions,
           data_out, next_row, next_col,
    input  new_pixel, center_addr, read_en, clear, update_strb, region_end,
           region_size, busy, done
  );
endinterface

// File: rtl/eda_fifo_arbiter.sv
// Neighbour-FIFO pop arbiter. Fixed priority (highest index wins) by default;
// EDA_REGION_CTRL_RR_ARB_EN selects round-robin starting after the last grant.
module eda_fifo_arbiter
  import eda_region_pkg::*;
#(
  parameter int NUM_FIFO = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_FIFO-1:0] req_i,
  input  logic                adv_i,
  output logic [NUM_FIFO-1:0] gnt_o
);

`ifdef EDA_REGION_CTRL_RR_ARB_EN
  localparam int PTR_W = (NUM_FIFO > 1) ? $clog2(NUM_FIFO) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] idx;

  // Scan from the far end back toward ptr+1 so the nearest requester wins.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    idx   = '0;
    for (int k = NUM_FIFO; k >= 1; k--) begin
      idx = PTR_W'((int'(ptr_q) + k) % NUM_FIFO);
      if (req_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
        if (adv_i) ptr_d = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end
`else
  always_comb begin
    gnt_o = '0;
    for (int k = 0; k < NUM_FIFO; k++) begin
      if (req_i[k]) begin
        gnt_o    = '0;
        gnt_o[k] = 1'b1;
      end
    end
  end

  logic unused_rr;
  assign unused_rr = clk ^ reset_n ^ adv_i;
`endif

endmodule

// File: rtl/eda_region_ctrl.sv
// Flood-fill sequencer: raster seeding, neighbour-FIFO draining, region sizing.
// Arbitration is fixed priority unless EDA_REGION_CTRL_RR_ARB_EN is defined.
module eda_region_ctrl
  import eda_region_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int I_WIDTH     = 8,
  parameter int J_WIDTH     = 8,
  parameter int ADDR_WIDTH  = addr_width(I_WIDTH, J_WIDTH),
  parameter int NUM_FIFO    = 8,
  parameter int RD_LATENCY  = 1,
  parameter int SIZE_WIDTH  = size_width(ADDR_WIDTH)
) (
  input logic               clk,
  input logic               reset_n,
  eda_region_ctrl_if.master bus
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    WAIT_CNT_W'((RD_LATENCY > RD_LATENCY_MAX) ? RD_LATENCY_MAX : RD_LATENCY);

  function automatic logic [SIZE_WIDTH-1:0] sat_inc(input logic [SIZE_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_q, wait_d;
  logic [SIZE_WIDTH-1:0] size_q, size_d;
  logic [SIZE_WIDTH-1:0] rsize_q, rsize_d;
  logic [ADDR_WIDTH-1:0] center_q, center_d;
  logic                  new_pixel_q, new_pixel_d;
  logic                  clear_q, clear_d;
  logic                  update_q, update_d;
  logic                  rend_q, rend_d;
  logic [NUM_FIFO-1:0]   gnt;
  logic [NUM_FIFO-1:0]   read_en;
  logic                  all_empty;
  logic                  unused_cfg;

  assign unused_cfg = PIXEL_WIDTH[0];
  assign all_empty  = &bus.fifo_empty;

  eda_fifo_arbiter #(.NUM_FIFO(NUM_FIFO)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req_i   (~bus.fifo_empty),
    .adv_i   (|read_en),
    .gnt_o   (gnt)
  );

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    size_d      = size_q;
    rsize_d     = rsize_q;
    center_d    = center_q;
    new_pixel_d = 1'b0;
    clear_d     = 1'b0;
    update_d    = 1'b0;
    rend_d      = 1'b0;
    read_en     = '0;
    if (bus.abort) begin
      state_d = ST_IDLE;
      clear_d = 1'b1;
      size_d  = '0;
      wait_d  = '0;
    end else if (!bus.stall) begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            clear_d = 1'b1;
            state_d = ST_SEED;
          end
        end
        ST_SEED: begin
          if (bus.iterated_all) begin
            state_d = ST_DONE;
          end else begin
            center_d    = {bus.next_row, bus.next_col};
            new_pixel_d = 1'b1;
            update_d    = 1'b1;
            size_d      = '0;
            wait_d      = WAIT_LOAD;
            state_d     = ST_WAIT;
          end
        end
        // The extra count-to-zero cycle covers the RAM's address register.
        ST_WAIT: begin
          if (wait_q == '0) state_d = ST_EVAL;
          else              wait_d  = wait_q - 1'b1;
        end
        ST_EVAL: begin
          size_d = sat_inc(size_q);
          if (!(|bus.push_positions) && all_empty) begin
            rend_d  = 1'b1;
            rsize_d = sat_inc(size_q);
            state_d = ST_SEED;
          end else begin
            state_d = ST_EXTEND;
          end
        end
        ST_EXTEND: begin
          if (all_empty) begin
            rend_d  = 1'b1;
            rsize_d = size_q;
            state_d = ST_SEED;
          end else begin
            read_en     = gnt;
            center_d    = bus.data_out;
            new_pixel_d = 1'b1;
            wait_d      = WAIT_LOAD;
            state_d     = ST_WAIT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      wait_q      <= '0;
      size_q      <= '0;
      rsize_q     <= '0;
      center_q    <= '0;
      new_pixel_q <= 1'b0;
      clear_q     <= 1'b0;
      update_q    <= 1'b0;
      rend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      size_q      <= size_d;
      rsize_q     <= rsize_d;
      center_q    <= center_d;
      new_pixel_q <= new_pixel_d;
      clear_q     <= clear_d;
      update_q    <= update_d;
      rend_q      <= rend_d;
    end
  end

  assign bus.new_pixel   = new_pixel_q;
  assign bus.center_addr = center_q;
  assign bus.read_en     = read_en;
  assign bus.clear       = clear_q;
  assign bus.update_strb = update_q;
  assign bus.region_end  = rend_q;
  assign bus.region_size = rsize_q;
  assign bus.busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign bus.done        = (state_q == ST_DONE);

endmodule
